// File: rtl/sfr_gpio_port_if.sv
// ---------------------------------------------------------------------------
// sfr_gpio_port_if
// CPU-side SFR bus seen by the GPIO port.
//   D_IN     - store data from the CPU
//   OUT_WE   - write strobe for the output-data register
//   DIR_WE   - write strobe for the direction register
//   IN_WE    - write-1-to-clear strobe for the change flags
//   Address  - SFR address used for read-back selection
//   RD_DATA  - combinational read-back data returned to the CPU load path
// The master modport is the CPU/decoder side; the slave modport is the port.
// ---------------------------------------------------------------------------
interface sfr_gpio_port_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D_IN;
  logic             OUT_WE;
  logic             DIR_WE;
  logic             IN_WE;
  logic [7:0]       Address;
  logic [WIDTH-1:0] RD_DATA;

  modport master (
    output D_IN,
    output OUT_WE,
    output DIR_WE,
    output IN_WE,
    output Address,
    input  RD_DATA
  );

  modport slave (
    input  D_IN,
    input  OUT_WE,
    input  DIR_WE,
    input  IN_WE,
    input  Address,
    output RD_DATA
  );
endinterface

// File: rtl/sfr_gpio_port.sv
// ---------------------------------------------------------------------------
// sfr_gpio_port
// Special-function-register GPIO port. Holds the output-data and direction
// registers written by the SFR decoder strobes, synchronises the external
// pins, latches change-of-state flags on input pins and raises an interrupt.
//   CLK       - system clock, rising edge
//   RST       - asynchronous, active-high reset
//   bus       - SFR bus (store data, write strobes, address, read-back)
//   PIN_IN    - asynchronous external pin levels
//   PIN_OUT   - output-data register
//   PIN_OE    - direction register, 1 = pin driven by the port
//   CHG_FLAGS - latched change flags (input pins only)
//   CHG_IRQ   - OR of CHG_FLAGS
// SYNC_STAGES must lie in 2..4.
// ---------------------------------------------------------------------------
module sfr_gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  sfr_gpio_port_if.slave   bus,
  input  logic [WIDTH-1:0] PIN_IN,
  output logic [WIDTH-1:0] PIN_OUT,
  output logic [WIDTH-1:0] PIN_OE,
  output logic [WIDTH-1:0] CHG_FLAGS,
  output logic             CHG_IRQ
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);

  typedef enum logic {
    WARM,
    RUN
  } state_t;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_oe;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_flags;
  logic [CNT_W-1:0] r_count;
  state_t           r_state;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_pending;
  logic [WIDTH-1:0] w_clear;
  logic [CNT_W-1:0] w_next_count;
  state_t           w_next_state;
  logic             w_detect_en;

  // Port registers; the decoder strobes are independent so both may load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out <= '0;
      r_oe  <= '0;
    end else begin
      if (bus.OUT_WE) r_out <= bus.D_IN;
      if (bus.DIR_WE) r_oe  <= bus.D_IN;
    end
  end

  // Pin synchroniser chain plus the previous-sample register used for
  // edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= PIN_IN;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync;
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Warm-up state register. The counter runs only while warming up.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= WARM;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
    end
  end

  // Warm-up next-state logic. Detection stays off until the counter has
  // covered the synchroniser fill plus the PREV update, so pin levels
  // present at reset release are absorbed without raising flags. The move
  // to RUN coincides with the counter reaching SYNC_STAGES+1.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_detect_en  = 1'b0;
    case (r_state)
      WARM: begin
        w_next_count = r_count + CNT_W'(1);
        if (r_count == CNT_W'(SYNC_STAGES)) w_next_state = RUN;
      end
      RUN: begin
        w_detect_en = 1'b1;
      end
      default: begin
        w_next_state = WARM;
      end
    endcase
  end

  // Only pins configured as inputs may raise a change.
  assign w_pending = w_detect_en ? ((w_sync ^ r_prev) & ~r_oe) : '0;
  assign w_clear   = bus.IN_WE ? bus.D_IN : '0;

  // Flag update: clearing first, then OR in new changes so a change that
  // lands in the same cycle as its clear is not lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_flags <= '0;
    end else begin
      r_flags <= (r_flags & ~w_clear) | w_pending;
    end
  end

  // Read-back mux; pin readback shows the driven value on outputs and the
  // synchronised level on inputs.
  always_comb begin
    bus.RD_DATA = '0;
    case (bus.Address)
      8'h01:   bus.RD_DATA = r_out;
      8'h02:   bus.RD_DATA = r_oe;
      8'h03:   bus.RD_DATA = (r_oe & r_out) | (~r_oe & w_sync);
      default: bus.RD_DATA = '0;
    endcase
  end

  assign PIN_OUT   = r_out;
  assign PIN_OE    = r_oe;
  assign CHG_FLAGS = r_flags;
  assign CHG_IRQ   = |r_flags;

endmodule

// File: tb/tb_sfr_gpio_port.sv
// ---------------------------------------------------------------------------
// tb_sfr_gpio_port
// Directed testbench for sfr_gpio_port: reset and warm-up, register writes
// and read-back, change detection latency, write-1-to-clear, set-wins-over-
// clear, direction changes and asynchronous reset mid-cycle.
// ---------------------------------------------------------------------------
module tb_sfr_gpio_port;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] PIN_IN;
  logic [WIDTH-1:0] PIN_OUT;
  logic [WIDTH-1:0] PIN_OE;
  logic [WIDTH-1:0] CHG_FLAGS;
  logic             CHG_IRQ;

  int checks = 0;
  int errors = 0;

  sfr_gpio_port_if #(.WIDTH(WIDTH)) bus_if ();

  sfr_gpio_port #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus_if.slave),
    .PIN_IN    (PIN_IN),
    .PIN_OUT   (PIN_OUT),
    .PIN_OE    (PIN_OE),
    .CHG_FLAGS (CHG_FLAGS),
    .CHG_IRQ   (CHG_IRQ)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges; inputs are driven and outputs sampled 1ns later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic write_reg(input logic [1:0] which, input logic [7:0] data);
    bus_if.D_IN   = data;
    bus_if.OUT_WE = (which == 2'd1);
    bus_if.DIR_WE = (which == 2'd2);
    bus_if.IN_WE  = (which == 2'd3);
    tick(1);
    bus_if.OUT_WE = 1'b0;
    bus_if.DIR_WE = 1'b0;
    bus_if.IN_WE  = 1'b0;
    bus_if.D_IN   = 8'h00;
  endtask

  task automatic test_reset;
    RST            = 1'b1;
    PIN_IN         = 8'hFF;
    bus_if.D_IN    = 8'h00;
    bus_if.OUT_WE  = 1'b0;
    bus_if.DIR_WE  = 1'b0;
    bus_if.IN_WE   = 1'b0;
    bus_if.Address = 8'h03;
    tick(3);
    RST = 1'b0;
    #1;
    checks++;
    if (PIN_OUT !== 8'h00 || PIN_OE !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_regs: PIN_OUT=%h PIN_OE=%h expected 00 00", PIN_OUT, PIN_OE);
    end
    checks++;
    if (bus_if.RD_DATA !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_sync: got %h expected 00", bus_if.RD_DATA);
    end
    tick(2);
    checks++;
    if (bus_if.RD_DATA !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL reset_readback_2cyc: got %h expected FF", bus_if.RD_DATA);
    end
    tick(3);
    checks++;
    if (CHG_FLAGS !== 8'h00 || CHG_IRQ !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_warmup_flags: flags=%h irq=%b expected 00 0", CHG_FLAGS, CHG_IRQ);
    end
  endtask

  task automatic test_reg_write;
    write_reg(2'd1, 8'hA5);
    checks++;
    if (PIN_OUT !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL out_write: got %h expected A5", PIN_OUT);
    end
    write_reg(2'd2, 8'h0F);
    checks++;
    if (PIN_OE !== 8'h0F || PIN_OUT !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL dir_write: PIN_OE=%h PIN_OUT=%h expected 0F A5", PIN_OE, PIN_OUT);
    end
    bus_if.Address = 8'h01;
    #1;
    checks++;
    if (bus_if.RD_DATA !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL read_01: got %h expected A5", bus_if.RD_DATA);
    end
    bus_if.Address = 8'h02;
    #1;
    checks++;
    if (bus_if.RD_DATA !== 8'h0F) begin
      errors++;
      $display("[TB] FAIL read_02: got %h expected 0F", bus_if.RD_DATA);
    end
    bus_if.Address = 8'h04;
    #1;
    checks++;
    if (bus_if.RD_DATA !== 8'h00) begin
      errors++;
      $display("[TB] FAIL read_other: got %h expected 00", bus_if.RD_DATA);
    end
    bus_if.Address = 8'h03;
    PIN_IN = 8'h30;
    tick(2);
    checks++;
    if (bus_if.RD_DATA !== 8'h35) begin
      errors++;
      $display("[TB] FAIL read_03_mixed: got %h expected 35", bus_if.RD_DATA);
    end
    checks++;
    if (CHG_FLAGS !== 8'h00) begin
      errors++;
      $display("[TB] FAIL flag_latency_early: got %h expected 00", CHG_FLAGS);
    end
    // FF->30 changes inputs 7 and 6; bits 3..0 are outputs and must not flag.
    tick(1);
    checks++;
    if (CHG_FLAGS !== 8'hC0 || CHG_IRQ !== 1'b1) begin
      errors++;
      $display("[TB] FAIL input_only_flags: flags=%h irq=%b expected C0 1", CHG_FLAGS, CHG_IRQ);
    end
    write_reg(2'd3, 8'hFF);
    checks++;
    if (CHG_FLAGS !== 8'h00 || CHG_IRQ !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_all: flags=%h irq=%b expected 00 0", CHG_FLAGS, CHG_IRQ);
    end
  endtask

  task automatic test_change_detect;
    PIN_IN = 8'h20;
    tick(2);
    checks++;
    if (CHG_FLAGS !== 8'h00 || CHG_IRQ !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bit4_latency_2edges: flags=%h irq=%b expected 00 0", CHG_FLAGS, CHG_IRQ);
    end
    tick(1);
    checks++;
    if (CHG_FLAGS !== 8'h10 || CHG_IRQ !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bit4_flag: flags=%h irq=%b expected 10 1", CHG_FLAGS, CHG_IRQ);
    end
    write_reg(2'd3, 8'hFF);
    PIN_IN = 8'h21;
    tick(5);
    checks++;
    if (CHG_FLAGS !== 8'h00 || CHG_IRQ !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bit0_output_no_flag: flags=%h irq=%b expected 00 0", CHG_FLAGS, CHG_IRQ);
    end
  endtask

  task automatic test_clear;
    PIN_IN = 8'h11;
    tick(3);
    checks++;
    if (CHG_FLAGS !== 8'h30) begin
      errors++;
      $display("[TB] FAIL two_flags: got %h expected 30", CHG_FLAGS);
    end
    write_reg(2'd3, 8'h10);
    checks++;
    if (CHG_FLAGS !== 8'h20 || CHG_IRQ !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_bit4: flags=%h irq=%b expected 20 1", CHG_FLAGS, CHG_IRQ);
    end
    write_reg(2'd3, 8'h20);
    checks++;
    if (CHG_FLAGS !== 8'h00 || CHG_IRQ !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_bit5: flags=%h irq=%b expected 00 0", CHG_FLAGS, CHG_IRQ);
    end
  endtask

  task automatic test_set_wins;
    // Flag 5 first, so a clear that loses to a new set is visible.
    PIN_IN = 8'h31;
    tick(3);
    PIN_IN = 8'h11;
    tick(2);
    write_reg(2'd3, 8'h20);
    checks++;
    if (CHG_FLAGS !== 8'h20) begin
      errors++;
      $display("[TB] FAIL set_wins_clear: got %h expected 20", CHG_FLAGS);
    end
    write_reg(2'd2, 8'hFF);
    checks++;
    if (CHG_FLAGS !== 8'h20 || PIN_OE !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL flag_survives_dir: flags=%h oe=%h expected 20 FF", CHG_FLAGS, PIN_OE);
    end
    PIN_IN = 8'h00;
    tick(4);
    checks++;
    if (CHG_FLAGS !== 8'h20) begin
      errors++;
      $display("[TB] FAIL all_outputs_no_flag: got %h expected 20", CHG_FLAGS);
    end
  endtask

  task automatic test_async_reset;
    write_reg(2'd2, 8'h00);
    write_reg(2'd1, 8'h55);
    PIN_IN = 8'hFF;
    tick(3);
    checks++;
    if (CHG_FLAGS !== 8'hFF || PIN_OUT !== 8'h55) begin
      errors++;
      $display("[TB] FAIL pre_reset_state: flags=%h out=%h expected FF 55", CHG_FLAGS, PIN_OUT);
    end
    #2;
    RST = 1'b1;
    bus_if.Address = 8'h01;
    #1;
    checks++;
    if (PIN_OUT !== 8'h00 || PIN_OE !== 8'h00 || CHG_FLAGS !== 8'h00 ||
        CHG_IRQ !== 1'b0 || bus_if.RD_DATA !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: out=%h oe=%h flags=%h irq=%b rd=%h expected all 0",
               PIN_OUT, PIN_OE, CHG_FLAGS, CHG_IRQ, bus_if.RD_DATA);
    end
    tick(1);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (CHG_FLAGS !== 8'h00 || CHG_IRQ !== 1'b0) begin
        errors++;
        $display("[TB] FAIL warmup_no_flag[%0d]: flags=%h irq=%b expected 00 0",
                 i, CHG_FLAGS, CHG_IRQ);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_change_detect();
    test_clear();
    test_set_wins();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
